// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the instruction/data RAM arbiter.
// - resp_e: what the RAM port is doing in the cycle after a grant, which
//   decides where the registered read data is routed.
// - WORD_BYTES / OFFSET_W: byte-to-word address conversion.
package mem_arb_pkg;

    localparam int WORD_BYTES = 4;
    localparam int OFFSET_W   = 2;

    typedef enum logic [2:0] {
        RESP_NONE  = 3'd0,
        RESP_IF_RD = 3'd1,
        RESP_D_RD  = 3'd2,
        RESP_D_WR  = 3'd3,
        RESP_D_ERR = 3'd4
    } resp_e;

endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio
// Priority decision between fetch and data with bounded fetch starvation.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   if_req, d_req   pending fetch / data requests
//   grant_if        fetch wins this cycle (combinational)
//   grant_d         data wins this cycle (combinational)
// Data normally wins; once fetch has lost STARVE_LIMIT consecutive contested
// cycles it is granted. Both grants are held low while rst is high.
module mem_arb_prio #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic d_req,
    output logic grant_if,
    output logic grant_d
);

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_r;
    logic [3:0] starve_cnt_next_s;

    // Grant decision: data first unless fetch has waited long enough.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (rst) begin
            grant_if = 1'b0;
            grant_d  = 1'b0;
        end else if (d_req && if_req) begin
            if (starve_cnt_r < LIMIT_C) begin
                grant_d = 1'b1;
            end else begin
                grant_if = 1'b1;
            end
        end else if (d_req) begin
            grant_d = 1'b1;
        end else if (if_req) begin
            grant_if = 1'b1;
        end else begin
            grant_if = 1'b0;
            grant_d  = 1'b0;
        end
    end

    // Counter next value: counts contested cycles that fetch lost. It can
    // only count up while below the limit, so it never exceeds it.
    always_comb begin
        starve_cnt_next_s = starve_cnt_r;
        if (grant_if || !if_req) begin
            starve_cnt_next_s = 4'd0;
        end else if (grant_d) begin
            starve_cnt_next_s = starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_next_s = starve_cnt_r;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_r <= 4'd0;
        end else begin
            starve_cnt_r <= starve_cnt_next_s;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port, synchronous-read word RAM between instruction
// fetch and load/store. One RAM access per cycle; responses come back one
// cycle after the grant and are steered by the registered response state.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   if_req/if_addr -> if_gnt         fetch request, same-cycle grant
//   if_rvalid/if_rdata               fetch response (data 0 when invalid)
//   d_req/d_we/d_addr/d_wdata        data request, d_gnt same-cycle grant
//   d_rvalid/d_rdata/d_err           data response (load data, store ack,
//                                    or misalignment error)
//   ram_addr/ram_we/ram_wdata        RAM command (all 0 when idle)
//   ram_rdata                        RAM read data, one cycle after address
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    logic        grant_if_s;
    logic        grant_d_s;
    logic        d_misaligned_s;
    resp_e       resp_next_s;
    resp_e       resp_r;

    // Byte-offset bits of fetch and address bits above the RAM depth are
    // deliberately dropped (fetch is word-aligned, addresses wrap).
    logic        addr_unused_s;
    assign addr_unused_s = ^{if_addr[31:ADDR_W+OFFSET_W], if_addr[OFFSET_W-1:0],
                             d_addr[31:ADDR_W+OFFSET_W]};

    assign d_misaligned_s = (d_addr[OFFSET_W-1:0] != 2'b00);

    mem_arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .d_req    (d_req),
        .grant_if (grant_if_s),
        .grant_d  (grant_d_s)
    );

    assign if_gnt = grant_if_s;
    assign d_gnt  = grant_d_s;

    // RAM command: word index of the winner; a misaligned store is granted
    // but suppressed at the write enable.
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = 32'd0;
        if (grant_d_s) begin
            ram_addr  = d_addr[ADDR_W+OFFSET_W-1:OFFSET_W];
            ram_we    = d_we && !d_misaligned_s;
            ram_wdata = d_wdata;
        end else if (grant_if_s) begin
            ram_addr  = if_addr[ADDR_W+OFFSET_W-1:OFFSET_W];
            ram_we    = 1'b0;
            ram_wdata = 32'd0;
        end else begin
            ram_addr  = '0;
            ram_we    = 1'b0;
            ram_wdata = 32'd0;
        end
    end

    // Response type for the cycle after this grant.
    always_comb begin
        resp_next_s = RESP_NONE;
        if (grant_d_s) begin
            if (d_misaligned_s) begin
                resp_next_s = RESP_D_ERR;
            end else if (d_we) begin
                resp_next_s = RESP_D_WR;
            end else begin
                resp_next_s = RESP_D_RD;
            end
        end else if (grant_if_s) begin
            resp_next_s = RESP_IF_RD;
        end else begin
            resp_next_s = RESP_NONE;
        end
    end

    // Response-state register; async reset drops any pending response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_r <= RESP_NONE;
        end else begin
            resp_r <= resp_next_s;
        end
    end

    // Route the RAM read data to the owner of the outstanding response.
    always_comb begin
        if_rvalid = 1'b0;
        if_rdata  = 32'd0;
        d_rvalid  = 1'b0;
        d_rdata   = 32'd0;
        d_err     = 1'b0;
        case (resp_r)
            RESP_IF_RD: begin
                if_rvalid = 1'b1;
                if_rdata  = ram_rdata;
            end
            RESP_D_RD: begin
                d_rvalid = 1'b1;
                d_rdata  = ram_rdata;
            end
            RESP_D_WR: begin
                d_rvalid = 1'b1;
            end
            RESP_D_ERR: begin
                d_rvalid = 1'b1;
                d_err    = 1'b1;
            end
            default: begin
                if_rvalid = 1'b0;
                d_rvalid  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Table-driven bench for mem_arbiter with a behavioural synchronous-read RAM.
// Inputs change on the falling edge; outputs are compared 1 ns later.
module tb_mem_arbiter;

    localparam int ADDR_W       = 8;
    localparam int STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              d_req;
    logic              d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W       (ADDR_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // RAM macro model: write-on-edge, registered read (old data on collision).
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        logic        ifr;
        logic [31:0] ifa;
        logic        dr;
        logic        dwe;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        eig;
        logic        edg;
        logic        ewe;
        logic [7:0]  eaddr;
        logic [31:0] ewd;
        logic        eirv;
        logic [31:0] eird;
        logic        edrv;
        logic [31:0] edrd;
        logic        eerr;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ifr, input logic [31:0] ifa, input logic dr,
                         input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
        if_req  = ifr;
        if_addr = ifa;
        d_req   = dr;
        d_we    = dwe;
        d_addr  = da;
        d_wdata = dwd;
    endtask

    task automatic chk_quiet_resp(input string tag);
        chk({tag, " if_rvalid"}, {31'd0, if_rvalid}, 32'd0);
        chk({tag, " if_rdata"},  if_rdata, 32'd0);
        chk({tag, " d_rvalid"},  {31'd0, d_rvalid}, 32'd0);
        chk({tag, " d_rdata"},   d_rdata, 32'd0);
        chk({tag, " d_err"},     {31'd0, d_err}, 32'd0);
    endtask

    // Both requests held for n cycles; grant pattern must be D x LIMIT then IF.
    task automatic contention(input string tag, input int n);
        logic prev_if;
        logic exp_if;
        prev_if = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(1'b1, 32'h0000_000C, 1'b1, 1'b0, 32'h0000_0080, 32'd0);
            #1;
            exp_if = ((i % (STARVE_LIMIT + 1)) == STARVE_LIMIT);
            chk($sformatf("%s[%0d] if_gnt", tag, i), {31'd0, if_gnt}, {31'd0, exp_if});
            chk($sformatf("%s[%0d] d_gnt", tag, i), {31'd0, d_gnt}, {31'd0, !exp_if});
            chk($sformatf("%s[%0d] ram_addr", tag, i), {24'd0, ram_addr},
                exp_if ? 32'd3 : 32'h20);
            if (i > 0) begin
                chk($sformatf("%s[%0d] if_rvalid", tag, i), {31'd0, if_rvalid}, {31'd0, prev_if});
                chk($sformatf("%s[%0d] d_rvalid", tag, i), {31'd0, d_rvalid}, {31'd0, !prev_if});
                chk($sformatf("%s[%0d] rdata", tag, i), prev_if ? if_rdata : d_rdata,
                    prev_if ? 32'h0050_0093 : 32'hA5A5_A5A5);
            end
            prev_if = exp_if;
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'd0;
        mem[0]     = 32'h1111_2222;
        mem[3]     = 32'h0050_0093;
        mem[8'h10] = 32'hCAFE_F00D;
        mem[8'h20] = 32'hA5A5_A5A5;

        //             ifr   ifa            dr    dwe   da             dwd
        //             eig   edg   ewe   eaddr  ewd            eirv  eird           edrv  edrd           eerr
        vecs[0] = '{1'b1, 32'h0000_000C, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b0, 8'h03, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0041, 32'h1234_5678,
                    1'b0, 1'b1, 1'b0, 8'h10, 32'h0, 1'b1, 32'h0050_0093, 1'b0, 32'h0, 1'b0};
        vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0040, 32'h0,
                    1'b0, 1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1};
        vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF,
                    1'b0, 1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b0};
        vecs[4] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0040, 32'h0,
                    1'b0, 1'b1, 1'b0, 8'h10, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0};
        vecs[5] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0};
        vecs[6] = '{1'b1, 32'h0000_0400, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};
        vecs[7] = '{1'b1, 32'h0000_000D, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b1, 1'b0, 1'b0, 8'h03, 32'h0, 1'b1, 32'h1111_2222, 1'b0, 32'h0, 1'b0};
        vecs[8] = '{1'b1, 32'h0000_000C, 1'b1, 1'b0, 32'h0000_0080, 32'h0,
                    1'b0, 1'b1, 1'b0, 8'h20, 32'h0, 1'b1, 32'h0050_0093, 1'b0, 32'h0, 1'b0};
        vecs[9] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                    1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 1'b1, 32'hA5A5_A5A5, 1'b0};

        // Reset state: requests present but nothing may be granted or written.
        rst = 1'b1;
        drive(1'b1, 32'h0000_000C, 1'b1, 1'b1, 32'h0000_0040, 32'hFFFF_FFFF);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst if_gnt", {31'd0, if_gnt}, 32'd0);
        chk("rst d_gnt",  {31'd0, d_gnt},  32'd0);
        chk("rst ram_we", {31'd0, ram_we}, 32'd0);
        chk_quiet_resp("rst");
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);

        // Directed vector table.
        for (int v = 0; v < 10; v++) begin
            @(negedge clk);
            drive(vecs[v].ifr, vecs[v].ifa, vecs[v].dr, vecs[v].dwe, vecs[v].da, vecs[v].dwd);
            #1;
            chk($sformatf("v%0d if_gnt", v),    {31'd0, if_gnt},    {31'd0, vecs[v].eig});
            chk($sformatf("v%0d d_gnt", v),     {31'd0, d_gnt},     {31'd0, vecs[v].edg});
            chk($sformatf("v%0d ram_we", v),    {31'd0, ram_we},    {31'd0, vecs[v].ewe});
            chk($sformatf("v%0d ram_addr", v),  {24'd0, ram_addr},  {24'd0, vecs[v].eaddr});
            if (vecs[v].ewe || (!vecs[v].eig && !vecs[v].edg))
                chk($sformatf("v%0d ram_wdata", v), ram_wdata, vecs[v].ewd);
            chk($sformatf("v%0d if_rvalid", v), {31'd0, if_rvalid}, {31'd0, vecs[v].eirv});
            chk($sformatf("v%0d if_rdata", v),  if_rdata,           vecs[v].eird);
            chk($sformatf("v%0d d_rvalid", v),  {31'd0, d_rvalid},  {31'd0, vecs[v].edrv});
            chk($sformatf("v%0d d_rdata", v),   d_rdata,            vecs[v].edrd);
            chk($sformatf("v%0d d_err", v),     {31'd0, d_err},     {31'd0, vecs[v].eerr});
        end

        // Sustained contention from a cleared counter: D,D,D,D,IF repeating.
        contention("cont", 15);

        // Reset between a fetch grant and its response edge.
        @(negedge clk);
        drive(1'b1, 32'h0000_000C, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("rstA if_gnt before", {31'd0, if_gnt}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstA if_gnt in rst", {31'd0, if_gnt}, 32'd0);
        chk("rstA ram_we in rst", {31'd0, ram_we}, 32'd0);
        @(negedge clk);
        #1;
        chk_quiet_resp("rstA held");
        rst = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk_quiet_resp("rstA release");

        // Build up the starvation count, then reset: count must restart at 0.
        contention("pre", 3);
        #2;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        chk_quiet_resp("rstB release");
        contention("post", 5);

        @(negedge clk);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter and sequencer that shares one single-port, synchronous-read word RAM between the core's instruction-fetch path and its load/store path. It sits between the fetch/execute stages and the RAM macro and converts byte addresses to word indices. It issues at most one RAM access per cycle and routes each read response back to the requester that owns it. Data accesses have priority over fetch, and a bounded-starvation counter guarantees that fetch makes progress.

## Interface
- `ADDR_W`, default 8: word-index width; RAM depth is 2^ADDR_W words.
- `STARVE_LIMIT`, default 4: maximum number of consecutive cycles fetch may lose arbitration; range 1..15.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `if_req`  in  1: fetch request; held high with `if_addr` stable until granted.
- `if_addr`  in  32: fetch byte address.
- `if_gnt`  out  1: fetch accepted this cycle (combinational).
- `if_rvalid`  out  1: fetch response valid.
- `if_rdata`  out  32: instruction word; 0 when `if_rvalid`=0.
- `d_req`  in  1: data request; held with its fields stable until granted.
- `d_we`  in  1: 1 = store word, 0 = load word.
- `d_addr`  in  32: data byte address.
- `d_wdata`  in  32: store data.
- `d_gnt`  out  1: data accepted this cycle (combinational).
- `d_rvalid`  out  1: data response valid (load data or store ack).
- `d_rdata`  out  32: load data; 0 for store acks, errors, and when `d_rvalid`=0.
- `d_err`  out  1: qualifies `d_rvalid`; misaligned access.
- `ram_addr`  out  ADDR_W: word index, equal to `addr[ADDR_W+1:2]` of the granted request.
- `ram_we`  out  1: RAM write enable.
- `ram_wdata`  out  32: RAM write data.
- `ram_rdata`  in  32: RAM read data, valid one cycle after the address.

## Operation
- **Arbitration (combinational):**
  - `d_req` only: grant data.
  - `if_req` only: grant fetch.
  - Both requests, `starve_cnt` < `STARVE_LIMIT`: grant data and increment `starve_cnt`.
  - Both requests, `starve_cnt` == `STARVE_LIMIT`: grant fetch.
- **Starvation counter:** `starve_cnt` (4 bits) clears when fetch is granted or `if_req`=0. It never exceeds `STARVE_LIMIT`.
- **Misaligned data:** a data access is misaligned when `d_addr[1:0]`≠0.
  - It is granted normally, but `ram_we`=0 and no store occurs.
  - The response is `d_rvalid`=1, `d_err`=1.
- **Fetch alignment:** fetch ignores `if_addr[1:0]`. Address bits above `ADDR_W+1` are ignored (wrap-around).
- **Idle RAM port:** with no grant, `ram_we`=0 and `ram_addr`/`ram_wdata` hold 0.
- **Response-state register `resp_q`:** NONE, IF_RD, D_RD, D_WR, D_ERR. It is loaded every cycle from the current grant; no grant loads NONE.
- **Responses in the cycle after a grant:**
  - IF_RD: `if_rvalid`=1, `if_rdata`=`ram_rdata`.
  - D_RD: `d_rvalid`=1, `d_rdata`=`ram_rdata`.
  - D_WR: `d_rvalid`=1, `d_rdata`=0.
  - D_ERR: `d_rvalid`=1, `d_err`=1.
- **Throughput:** the arbiter is fully pipelined and can grant one request every cycle.

## Timing
- **Grant:** same cycle as the request; a request with `gnt`=0 must be held.
- **Latency:** exactly 1 cycle from grant to the `rvalid` pulse, for all request types. `rvalid` is a single-cycle pulse per grant.
- **Store timing:** the store is written at the edge ending the grant cycle. A load of the same word granted in the next cycle returns the new data.
- **Reset values:**
  - `resp_q`=NONE and `starve_cnt`=0.
  - All `rvalid`, `rdata`, and `d_err` outputs are 0.
  - While `rst`=1, both grants and `ram_we` are forced to 0.
- **Reset mid-operation:** a response pending from the grant before reset is discarded and never delivered.

## Structure
- **Package `mem_arb_pkg`:** holds the `resp_q` state enum and the `WORD_BYTES`/offset constants.
- **Sub-module `mem_arb_prio`:** contains the priority decision plus `starve_cnt`, and outputs `grant_if`/`grant_d`. The top level holds `resp_q`, the address slicing, and the response muxing.

## Test plan
- **Single fetch:** reset, preload word 3 = 0x00500093; `if_req`=1, `if_addr`=0x0C → `if_gnt`=1 in cycle 0, `ram_addr`=3; cycle 1: `if_rvalid`=1, `if_rdata`=0x00500093.
- **Store then load:** `d_we`=1, `d_addr`=0x40, `d_wdata`=0xDEADBEEF, granted; next cycle load 0x40 → `d_rvalid`=1 two cycles after the store grant, `d_rdata`=0xDEADBEEF; store-ack pulse observed with `d_rdata`=0.
- **Contention:** `if_req` and `d_req` held continuously, `STARVE_LIMIT`=4 → grant pattern D,D,D,D,IF repeating; fetch never waits more than 4 cycles.
- **Misaligned:** `d_we`=1, `d_addr`=0x41 → `d_gnt`=1, `ram_we`=0; next cycle `d_rvalid`=1, `d_err`=1; a later read of word 0x10 is unchanged.
- **Reset mid-operation:** fetch granted, `rst` asserted before the next edge → no `if_rvalid` pulse; all outputs 0; `starve_cnt` restarts from 0 after release.
- **Wrap:** `if_addr`=0x400 with `ADDR_W`=8 → `ram_addr`=0, returns word 0.
